// File: rtl/move_drain_sched.sv
// Pass scheduler for the column move generators: clears the columns, then drains
// their FIFOs round-robin into one registered valid/ready stream until all are done.
module move_drain_sched #(
  parameter int NCOL    = 8,
  parameter int DW      = 152,
  parameter int CLR_CYC = 2,
  parameter int CW      = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 col_rst,
  input  logic [NCOL-1:0]      col_done,
  input  logic [NCOL-1:0]      col_empty,
  output logic [NCOL-1:0]      col_rden,
  input  logic [NCOL*DW-1:0]   col_data,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 pass_done,
  output logic [CW-1:0]        word_count
);

  localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int KW = $clog2(CLR_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SCAN, S_READ, S_HOLD, S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_sel;
  logic [KW-1:0]   r_clr_cnt;
  logic [CW-1:0]   r_word_count;
  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_pass_done;
  logic            r_rst_hold;
  logic            w_found;
  logic [PW-1:0]   w_gnt;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCOL) s = s - NCOL;
    return PW'(s);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Round-robin search: first non-empty column at or after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NCOL; k++) begin
      if (!w_found && !col_empty[wrap_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_gnt   = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    col_rden = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_CLR;
      S_CLR:  if (r_clr_cnt == KW'(CLR_CYC - 1)) w_next = S_SCAN;
      S_SCAN: begin
        if (w_found) begin
          col_rden[w_gnt] = 1'b1;
          w_next          = S_READ;
        end else if (&col_done) begin
          w_next = S_FIN;
        end
      end
      S_READ: w_next = S_HOLD;
      S_HOLD: if (out_ready) w_next = S_SCAN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_rst_hold <= ~reset;
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_sel        <= '0;
      r_clr_cnt    <= '0;
      r_word_count <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_pass_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_clr_cnt    <= '0;
            r_word_count <= '0;
            r_pass_done  <= 1'b0;
          end
        end
        S_CLR: r_clr_cnt <= r_clr_cnt + KW'(1);
        S_SCAN: begin
          if (w_found)        r_sel       <= w_gnt;
          else if (&col_done) r_pass_done <= 1'b1;
        end
        // Non-showahead FIFO: q is valid the cycle after its rden.
        S_READ: begin
          r_out_data  <= col_data[int'(r_sel)*DW +: DW];
          r_out_valid <= 1'b1;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_word_count <= sat_inc(r_word_count);
            r_rr_ptr     <= wrap_idx(r_sel, 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign col_rst    = r_rst_hold | (r_state == S_CLR);
  assign busy       = (r_state == S_CLR) | (r_state == S_SCAN) |
                      (r_state == S_READ) | (r_state == S_HOLD);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign pass_done  = r_pass_done;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_move_drain_sched.sv
// Directed bench for move_drain_sched with a behavioural model of the eight
// non-showahead column FIFOs; grants and accepted words are logged for checking.
module tb_move_drain_sched;
  localparam int NCOL = 8;
  localparam int DW   = 152;
  localparam int CW   = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                col_rst;
  logic [NCOL-1:0]     col_done;
  logic [NCOL-1:0]     col_empty;
  logic [NCOL-1:0]     col_rden;
  logic [NCOL*DW-1:0]  col_data;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                pass_done;
  logic [CW-1:0]       word_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  move_drain_sched #(.NCOL(NCOL), .DW(DW), .CLR_CYC(2), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .col_rst(col_rst),
    .col_done(col_done), .col_empty(col_empty), .col_rden(col_rden),
    .col_data(col_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .pass_done(pass_done),
    .word_count(word_count)
  );

  // FIFO model: bench writes mem/wp, the clocked reader owns rp/q
  logic [DW-1:0] mem [NCOL][16];
  int            wp [NCOL];
  int            rp [NCOL];
  logic [DW-1:0] q  [NCOL];

  for (genvar g = 0; g < NCOL; g++) begin : g_fifo
    assign col_empty[g]          = (wp[g] == rp[g]);
    assign col_data[g*DW +: DW]  = q[g];
  end

  logic [DW-1:0] rlog [64];
  int            glog [64];
  int            rn = 0;
  int            gn = 0;
  bit            rden_bad = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NCOL; i++) begin
      if (col_rden[i]) begin
        q[i]  <= mem[i][rp[i] % 16];
        rp[i] <= rp[i] + 1;
        glog[gn % 64] <= i;
      end
    end
    if (col_rden != '0) gn <= gn + 1;
    if ($countones(col_rden) > 1) rden_bad <= 1'b1;
    if (reset && out_valid && out_ready) begin
      rlog[rn % 64] <= out_data;
      rn <= rn + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [DW-1:0] d);
    mem[c][wp[c] % 16] = d;
    wp[c] = wp[c] + 1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; col_done = '0;
    step(); step();
    for (int i = 0; i < NCOL; i++) wp[i] = rp[i];
    reset = 1'b1;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
    chk(nm, out_valid, 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (pass_done !== 1'b1 && n < 200) begin step(); n++; end
    chk(nm, pass_done, 1);
  endtask

  typedef struct {
    int              col;
    logic [DW-1:0]   data;
    logic [NCOL-1:0] exp_rden;
  } vec_t;

  initial begin
    vec_t vt [4];
    int   cols [3];
    int   g0, r0;

    vt[0] = '{2, DW'('hABC), 8'h04};
    vt[1] = '{0, DW'('h1),   8'h01};
    vt[2] = '{7, {16'hDEAD, 120'h0, 16'hBEEF}, 8'h80};
    vt[3] = '{5, DW'('h5A5), 8'h20};
    cols  = '{0, 3, 7};

    reset = 1'b0; start = 1'b0; col_done = '0; out_ready = 1'b0;
    for (int i = 0; i < NCOL; i++) wp[i] = 0;

    // reset state, clear phase, idle scan
    step(); step(); step();
    chk("rst_col_rst", col_rst, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_count", word_count, 0);
    chk("rst_rden", col_rden, 0);
    chk("rst_data", out_data, 0);
    reset = 1'b1;
    step();
    chk("idle_col_rst", col_rst, 0);
    do_start();
    chk("clr1_col_rst", col_rst, 1);
    chk("clr1_busy", busy, 1);
    step();
    chk("clr2_col_rst", col_rst, 1);
    step();
    chk("scan_col_rst", col_rst, 0);
    chk("scan_busy", busy, 1);
    chk("scan_rden", col_rden, 0);
    col_done = 8'hFF;
    step();
    chk("fin_pass_done", pass_done, 1);
    chk("fin_busy", busy, 0);
    step();
    chk("idle_pass_done", pass_done, 1);

    // single-word passes, one column each
    for (int v = 0; v < 4; v++) begin
      do_reset();
      push(vt[v].col, vt[v].data);
      out_ready = 1'b1;
      do_start();
      step(); step();
      chk("vec_rden", col_rden, vt[v].exp_rden);
      col_done = 8'hFF;
      step();
      chk("vec_read_valid", out_valid, 0);
      chk("vec_read_rden", col_rden, 0);
      step();
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vt[v].data);
      step();
      chk("vec_count", word_count, 1);
      step();
      chk("vec_pass_done", pass_done, 1);
      chk("vec_busy", busy, 0);
      step();
    end

    // round-robin across columns 0,3,7
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) push(cols[j], DW'(cols[j]*16 + k));
    g0 = gn; r0 = rn;
    out_ready = 1'b1; col_done = 8'hFF;
    do_start();
    wait_done("rr_done");
    chk("rr_count", word_count, 6);
    chk("rr_ngrant", gn - g0, 6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", glog[(g0 + i) % 64], cols[i % 3]);
      chk("rr_data", rlog[(r0 + i) % 64], DW'(cols[i % 3]*16 + i/3));
    end

    // backpressure
    do_reset();
    push(4, DW'('h444)); push(6, DW'('h666));
    g0 = gn;
    do_start();
    wait_valid("bp_valid");
    chk("bp_data", out_data, DW'('h444));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_data", out_data, DW'('h444));
      chk("bp_hold_valid", out_valid, 1);
    end
    chk("bp_count", word_count, 0);
    chk("bp_grants", gn - g0, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_acc_count", word_count, 1);
    chk("bp_acc_valid", out_valid, 0);
    chk("bp_next_rden", col_rden, 8'h40);
    wait_valid("bp_valid2");
    chk("bp_data2", out_data, DW'('h666));
    out_ready = 1'b1; col_done = 8'hFF;
    wait_done("bp_done");
    chk("bp_count2", word_count, 2);

    // done but not empty
    do_reset();
    push(5, DW'('h51)); push(5, DW'('h52)); push(5, DW'('h53));
    r0 = rn;
    col_done = 8'hFF; out_ready = 1'b1;
    do_start();
    wait_done("dne_done");
    chk("dne_count", word_count, 3);
    chk("dne_words", rn - r0, 3);
    for (int i = 0; i < 3; i++) chk("dne_data", rlog[(r0 + i) % 64], DW'('h51 + i));

    // late producer: column 7 not done
    do_reset();
    col_done = 8'h7F; out_ready = 1'b1;
    g0 = gn;
    do_start();
    repeat (20) step();
    chk("late_no_done", pass_done, 0);
    chk("late_busy", busy, 1);
    chk("late_no_grant", gn - g0, 0);
    r0 = rn;
    push(7, DW'('h777));
    repeat (6) step();
    col_done = 8'hFF;
    wait_done("late_done");
    chk("late_words", rn - r0, 1);
    chk("late_data", rlog[r0 % 64], DW'('h777));
    chk("late_count", word_count, 1);

    // start while busy, then reset in HOLD
    do_reset();
    push(3, DW'('h333));
    do_start();
    wait_valid("mid_valid");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_start_busy", busy, 1);
    chk("mid_start_valid", out_valid, 1);
    chk("mid_start_col_rst", col_rst, 0);
    chk("mid_start_data", out_data, DW'('h333));
    reset = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", word_count, 0);
    chk("mid_rst_col_rst", col_rst, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rden", col_rden, 0);
    chk("mid_rst_data", out_data, 0);
    reset = 1'b1;
    step();
    chk("mid_idle_col_rst", col_rst, 0);
    chk("mid_idle_busy", busy, 0);

    chk("rden_onehot", rden_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_drain_sched.md
Name: move_drain_sched

Overview:
- Board-level scheduler sequencing the eight column move-generator units through one generation pass.
- Pulses the shared column reset to start a pass, then drains the eight column FIFOs into a single output stream using round-robin arbitration with a valid/ready handshake.
- Declares the pass finished once every column reports done and all column FIFOs are empty.
- Sits between the column array and the downstream move consumer (search/evaluation logic).

Parameters:
- NCOL, 8, number of column units / FIFOs arbitrated.
- DW, 152, width of one column FIFO output word.
- CLR_CYC, 2, cycles the column reset is held at pass start.
- CW, 10, width of the move-word counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  begin a pass; sampled only in IDLE.
- col_rst  out  1  active-high reset to all column units.
- col_done  in  NCOL  per-column done flags.
- col_empty  in  NCOL  per-column FIFO empty flags.
- col_rden  out  NCOL  per-column FIFO read enables, one-hot or zero.
- col_data  in  NCOL*DW  column FIFO q buses; column i occupies bits [i*DW +: DW]. Data is valid one cycle after its rden (non-showahead FIFO).
- out_data  out  DW  registered move word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  high from accepted start until FIN.
- pass_done  out  1  held high from FIN until next accepted start or reset.
- word_count  out  CW  words delivered in the current pass.

Behaviour:

Reset (reset==0 at a clock edge):
- state=IDLE, rr_ptr=0, sel=0, clr_cnt=0, word_count=0.
- All outputs 0 except col_rst=1: columns are held in reset while this block is reset.
- Reset mid-pass abandons the pass immediately. The word in out_data is dropped, and no rden is issued on the following cycle.

States:
- IDLE
  - col_rst=0, busy=0.
  - start=1 → CLR; clr_cnt=0, word_count=0, pass_done=0.
- CLR
  - col_rst=1, busy=1, clr_cnt increments.
  - Leaves for SCAN on the cycle clr_cnt==CLR_CYC-1, so col_rst is high exactly CLR_CYC cycles.
- SCAN (single cycle)
  - Candidate set: ~col_empty.
  - If the set is non-empty: grant the first set bit at or after rr_ptr, wrapping 7→0. Set sel=that index, assert col_rden[sel]=1 this cycle only, go READ.
  - Otherwise, if &col_done: go FIN.
  - Otherwise stay in SCAN, with no rden.
  - No lookahead: the empty flag is sampled in the same cycle rden is driven.
- READ (single cycle)
  - Capture out_data=col_data[sel], set out_valid=1, go HOLD.
  - col_rden all 0.
- HOLD
  - out_valid and out_data held stable until out_ready=1.
  - On handshake, in the same edge: out_valid=0, word_count+1 (saturates at all-ones), rr_ptr=(sel+1) mod NCOL, go SCAN.
- FIN
  - pass_done=1, busy=0, go IDLE.
  - pass_done remains 1 in IDLE until the next accepted start.

Timing and invariants:
- Grant latency: SCAN → out_valid at the edge after READ, i.e. 2 cycles from rden to out_valid.
- Maximum throughput: one word per 3 cycles (SCAN, READ, HOLD with ready already high).
- At most one col_rden bit high at any time; never high outside SCAN.
- Fairness: after serving column k, column k+1 has top priority. Each non-empty column is served within NCOL grants.
- start while not IDLE is ignored.
- A column that is done but not empty keeps being drained; the pass ends only when all columns are done and all FIFOs are empty in the same SCAN cycle.
- A column deasserting empty late (done=0) is still served.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset/clear: hold reset=0 for 3 cycles → all outputs 0, col_rst=1. Release, pulse start → col_rst=1 for exactly 2 cycles, busy=1, then SCAN with rden=0.
- Single word: after start, col_empty=8'hFB (column 2 holds one word 0xABC). Model the FIFO: empty goes to 1 one cycle after rden, q=0xABC one cycle after rden. Then col_done=8'hFF → col_rden=8'h04 for 1 cycle, out_valid 2 cycles later with out_data=0xABC. With out_ready=1: word_count=1, then pass_done=1, busy=0.
- Round-robin: columns 0, 3 and 7 each hold 2 words, out_ready=1 → grant order 0,3,7,0,3,7; word_count=6; pass_done after all are done/empty.
- Backpressure: out_ready=0 for 10 cycles with a word pending → out_data stable, no further rden, word_count unchanged. Raise ready → single acceptance, count +1.
- Done-but-nonempty and late producer: col_done=8'hFF while column 5 holds 3 words → 3 words delivered before pass_done. Separately, with col_done=8'h7F and all FIFOs empty → stays in SCAN with no pass_done until column 7 asserts done.
- Reset mid-pass: assert reset=0 while in HOLD with out_valid=1 → next cycle out_valid=0, word_count=0, col_rst=1, state IDLE. start ignored while busy; a pulse during RUN changes nothing.
